featuremap_pad_writer: RTL

- Producer side of the RGB pixel FIFO that the featuremap conv2D filter blocks drain through rdreq/data_fifo_empty.
- Accepts one raw WIDTH x HEIGHT RGB frame from a valid/ready pixel stream and writes it into the FIFO as a zero-padded (WIDTH+2) x (HEIGHT+2) frame. This matches the filter's conv2D line width of WIDTH+2.
- Runs in raster order, honours fifo_full, and pulses frame_done after the last padded word.

---
 rtl/featuremap_pad_writer.sv | 113 +++++++++++
 1 files changed

// File: rtl/featuremap_pad_writer.sv
// featuremap_pad_writer
// Takes one raw WIDTH x HEIGHT RGB frame from a valid/ready pixel stream. It
// writes the frame into the conv2D input FIFO as a (WIDTH+2) x (HEIGHT+2)
// frame in raster order, with a one-pixel ring of +0.0 words around it.
// FIFO writes are issued combinationally in the same cycle, so a pixel is
// consumed exactly when it is written. Nothing is buffered, and nothing can
// be dropped or duplicated.
module featuremap_pad_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 112,
  parameter int HEIGHT     = 112
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DATA_WIDTH*3-1:0]   pix_in,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  input  logic                      fifo_full,
  output logic                      wrreq,
  output logic [DATA_WIDTH*3-1:0]   fifo_data,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam int RW = $clog2(HEIGHT + 2);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH + 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          border;
  logic          last_cell;

  // Position classification on the padded grid
  always_comb begin
    border    = (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);
    last_cell = (row == ROW_LAST) && (col == COL_LAST);
  end

  // Zero-latency write path: border cells emit +0.0 and interior cells pass the pixel through
  always_comb begin
    pix_ready = 1'b0;
    wrreq     = 1'b0;
    fifo_data = '0;
    if (state == RUN) begin
      if (border) begin
        wrreq = !fifo_full;
      end else begin
        pix_ready = !fifo_full;
        wrreq     = pix_valid && !fifo_full;
        if (pix_valid && !fifo_full) begin
          fifo_data = pix_in;
        end
      end
    end
  end

  // Frame sequencer: position counters advance only on an actual write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            row   <= '0;
            col   <= '0;
          end
        end
        RUN: begin
          if (wrreq) begin
            if (last_cell) begin
              state      <= DONE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              row        <= '0;
              col        <= '0;
            end else if (col == COL_LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
